sum_stream: RTL and testbench



---
 rtl/sum_stream_if.sv | 30 +++
 rtl/sum_stream.sv | 156 +++++++++++++++
 tb/tb_sum_stream.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sum_stream_if.sv
// sum_stream_if: input beat stream and output frame-result port of sum_stream.
// The design side uses the slave modport; the producer/consumer side uses master.
interface sum_stream_if #(
    parameter int L        = 4,
    parameter int DW       = 16,
    parameter int MAXBEATS = 16
);
    localparam int OW = DW + $clog2(L) + $clog2(MAXBEATS);
    localparam int CW = $clog2(MAXBEATS + 1);

    logic              in_valid;
    logic              in_ready;
    logic [L*DW-1:0]   in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_sum;
    logic [CW-1:0]     out_beats;
    logic              out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_beats, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_beats, out_ovf
    );
endinterface

// File: rtl/sum_stream.sv
// sum_stream: frame-based streaming sum reducer.
// Stage S1 adds the L lanes of an accepted beat; the accumulator stage adds
// beat sums until the last beat of a frame, then loads a one-deep output
// register holding the frame total, beat count and overflow flag.
module sum_stream #(
    parameter int L        = 4,
    parameter int DW       = 16,
    parameter int MAXBEATS = 16,
    parameter int SIGNED   = 0
) (
    input  logic         clk,
    input  logic         nreset,
    sum_stream_if.slave  bus
);
    localparam int OW = DW + $clog2(L) + $clog2(MAXBEATS);
    localparam int CW = $clog2(MAXBEATS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXBEATS);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } frame_state_e;

    // S1 pipeline register
    logic          s1_valid_q, s1_valid_d;
    logic          s1_last_q,  s1_last_d;
    logic [OW-1:0] s1_sum_q,   s1_sum_d;

    // accumulator stage
    frame_state_e  state_q, state_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    // output register
    logic          out_valid_q, out_valid_d;
    logic [OW-1:0] out_sum_q,   out_sum_d;
    logic [CW-1:0] out_beats_q, out_beats_d;
    logic          out_ovf_q,   out_ovf_d;

    // combinational helpers
    logic          adv;
    logic [OW-1:0] lane_sum;
    logic [DW-1:0] lane;
    logic [OW-1:0] acc_base;
    logic [OW-1:0] sum_next;
    logic          cnt_sat;
    logic [CW-1:0] cnt_upd;
    logic          ovf_upd;

    // The only stall: S1 holds a last beat that cannot move into a full, untaken output register.
    assign adv          = ~(s1_valid_q & s1_last_q & out_valid_q & ~bus.out_ready);
    assign bus.in_ready = adv & nreset;

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_beats = out_beats_q;
    assign bus.out_ovf   = out_ovf_q;

    // Sum the incoming lanes, each widened to OW bits with zero or sign extension.
    always_comb begin
        lane_sum = '0;
        lane     = '0;
        for (int i = 0; i < L; i++) begin
            lane = bus.in_data[i*DW +: DW];
            if (SIGNED != 0) begin
                lane_sum = lane_sum + OW'($signed(lane));
            end else begin
                lane_sum = lane_sum + OW'(lane);
            end
        end
    end

    // S1 next state: load a new beat (or a bubble) whenever the pipe advances.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_sum_d   = s1_sum_q;
        if (adv) begin
            s1_valid_d = bus.in_valid;
            s1_last_d  = bus.in_valid & bus.in_last;
            if (bus.in_valid) begin
                s1_sum_d = lane_sum;
            end
        end
    end

    // Accumulator frame FSM and output register next state.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;

        acc_base = (state_q == ACC) ? acc_q : '0;
        sum_next = acc_base + s1_sum_q;
        cnt_sat  = (cnt_q == CNT_MAX);
        cnt_upd  = cnt_sat ? cnt_q : cnt_q + CW'(1);
        ovf_upd  = ovf_q | cnt_sat;

        if (out_valid_q & bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (adv & s1_valid_q) begin
            if (!s1_last_q) begin
                acc_d   = sum_next;
                cnt_d   = cnt_upd;
                ovf_d   = ovf_upd;
                state_d = ACC;
            end else begin
                out_sum_d   = sum_next;
                out_beats_d = cnt_upd;
                out_ovf_d   = ovf_upd;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                state_d     = IDLE;
            end
        end
    end

    // All state registers; reset discards S1, the partial frame and any pending result.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sum_q    <= '0;
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_sum_q    <= s1_sum_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_sum_stream.sv
// tb_sum_stream: directed bench for sum_stream with L=4, DW=8, MAXBEATS=4.
// An unsigned and a signed instance receive identical stimulus.
module tb_sum_stream;
    localparam int L  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic        clk       = 1'b0;
    logic        nreset    = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_last   = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_data   = '0;

    int compared   = 0;
    int mismatched = 0;

    sum_stream_if #(.L(L), .DW(DW), .MAXBEATS(MB)) bus_u ();
    sum_stream_if #(.L(L), .DW(DW), .MAXBEATS(MB)) bus_s ();

    assign bus_u.in_valid  = in_valid;
    assign bus_u.in_data   = in_data;
    assign bus_u.in_last   = in_last;
    assign bus_u.out_ready = out_ready;
    assign bus_s.in_valid  = in_valid;
    assign bus_s.in_data   = in_data;
    assign bus_s.in_last   = in_last;
    assign bus_s.out_ready = out_ready;

    sum_stream #(.L(L), .DW(DW), .MAXBEATS(MB), .SIGNED(0)) u_dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus_u)
    );

    sum_stream #(.L(L), .DW(DW), .MAXBEATS(MB), .SIGNED(1)) s_dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus_s)
    );

    // free-running clock
    always #5 clk = ~clk;

    // hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic last);
        in_valid = v;
        in_data  = d;
        in_last  = last;
    endtask

    task automatic sendFrame(input logic [31:0] d, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            applyStimulus(1'b1, d, (i == nbeats - 1));
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0);
        tick();
    endtask

    // directed test sequence
    initial begin
        $display("[TB] start");
        @(negedge clk);
        @(negedge clk);

        // reset values
        checkOutput("rst_out_valid", bus_u.out_valid, 32'd0);
        checkOutput("rst_out_sum",   bus_u.out_sum,   32'd0);
        checkOutput("rst_out_beats", bus_u.out_beats, 32'd0);
        checkOutput("rst_out_ovf",   bus_u.out_ovf,   32'd0);
        checkOutput("rst_in_ready",  bus_u.in_ready,  32'd0);
        nreset = 1'b1;
        #1;
        checkOutput("rel_in_ready",  bus_u.in_ready,  32'd1);

        // unsigned full-scale, 4 beats, latency check
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
        tick();
        tick();
        tick();
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("full_early_valid", bus_u.out_valid, 32'd0);
        tick();
        checkOutput("full_valid", bus_u.out_valid, 32'd1);
        checkOutput("full_sum",   bus_u.out_sum,   32'd4080);
        checkOutput("full_beats", bus_u.out_beats, 32'd4);
        checkOutput("full_ovf",   bus_u.out_ovf,   32'd0);
        tick();
        checkOutput("full_drained", bus_u.out_valid, 32'd0);

        // signed most-negative, then mixed single beat
        sendFrame(32'h8080_8080, 4);
        checkOutput("sneg_valid", bus_s.out_valid, 32'd1);
        checkOutput("sneg_sum",   bus_s.out_sum,   32'h800);
        checkOutput("sneg_beats", bus_s.out_beats, 32'd4);
        checkOutput("sneg_ovf",   bus_s.out_ovf,   32'd0);
        sendFrame(32'h8000_FF7F, 1);
        checkOutput("smix_sum",   bus_s.out_sum,   32'hFFE);
        checkOutput("smix_beats", bus_s.out_beats, 32'd1);

        // overflow: 5 beats of full scale
        sendFrame(32'hFFFF_FFFF, 5);
        checkOutput("ovf_flag",   bus_u.out_ovf,   32'd1);
        checkOutput("ovf_beats",  bus_u.out_beats, 32'd4);
        checkOutput("ovf_sum",    bus_u.out_sum,   32'd1004);
        checkOutput("ovf_s_sum",  bus_s.out_sum,   32'd4076);
        checkOutput("ovf_s_flag", bus_s.out_ovf,   32'd1);

        // backpressure: two single-beat frames with the consumer stalled
        tick();
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h0101_0101, 1'b1);
        tick();
        checkOutput("bp_rdy_a",   bus_u.in_ready,  32'd1);
        checkOutput("bp_valid_a", bus_u.out_valid, 32'd0);
        applyStimulus(1'b1, 32'h0202_0202, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("bp_valid_1", bus_u.out_valid, 32'd1);
        checkOutput("bp_sum_1",   bus_u.out_sum,   32'd4);
        checkOutput("bp_ovf_1",   bus_u.out_ovf,   32'd0);
        checkOutput("bp_rdy_low", bus_u.in_ready,  32'd0);
        tick();
        checkOutput("bp_hold_sum",   bus_u.out_sum,   32'd4);
        checkOutput("bp_hold_beats", bus_u.out_beats, 32'd1);
        checkOutput("bp_hold_valid", bus_u.out_valid, 32'd1);
        checkOutput("bp_hold_rdy",   bus_u.in_ready,  32'd0);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_rdy_comb", bus_u.in_ready, 32'd1);
        tick();
        checkOutput("bp_valid_2", bus_u.out_valid, 32'd1);
        checkOutput("bp_sum_2",   bus_u.out_sum,   32'd8);
        tick();
        checkOutput("bp_drained", bus_u.out_valid, 32'd0);

        // back-to-back single-beat frames at full rate
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) begin
                applyStimulus(1'b1, {4{8'(k)}}, 1'b1);
            end else begin
                applyStimulus(1'b0, '0, 1'b0);
            end
            tick();
            checkOutput("b2b_rdy", bus_u.in_ready, 32'd1);
            if (k >= 2) begin
                checkOutput("b2b_valid", bus_u.out_valid, 32'd1);
                checkOutput("b2b_sum",   bus_u.out_sum,   32'(4 * (k - 1)));
            end
        end
        tick();
        checkOutput("b2b_drained", bus_u.out_valid, 32'd0);

        // reset in the middle of a frame
        applyStimulus(1'b1, 32'h0A0A_0A0A, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        nreset = 1'b0;
        #1;
        checkOutput("mrst_valid", bus_u.out_valid, 32'd0);
        checkOutput("mrst_sum",   bus_u.out_sum,   32'd0);
        checkOutput("mrst_beats", bus_u.out_beats, 32'd0);
        checkOutput("mrst_ovf",   bus_u.out_ovf,   32'd0);
        checkOutput("mrst_rdy",   bus_u.in_ready,  32'd0);
        tick();
        nreset = 1'b1;
        sendFrame(32'h0101_0101, 1);
        checkOutput("after_rst_valid", bus_u.out_valid, 32'd1);
        checkOutput("after_rst_sum",   bus_u.out_sum,   32'd4);
        checkOutput("after_rst_beats", bus_u.out_beats, 32'd1);
        checkOutput("after_rst_ovf",   bus_u.out_ovf,   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
